uop_sequencer: RTL
==================

Name: uop_sequencer

Overview:
Back-end consumer of the decode unit's micro-op handshake. It raises feed_req, captures the decoder's micro-op bundle (uop_0..uop_2, uop_count) on feed_ack, and issues the micro-ops one per cycle, oldest first, to the execute stage under a valid/ready handshake. It also provides flush and hold handling and a retired-instruction counter.

Parameters:
UOP_W, 20, micro-op word width (must match the decoder bundle)
CNT_W, 2, width of uop_count
PERF_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  core clock
a_rst  in  1  asynchronous, active-high reset
hold  in  1  global stall; freezes all state
flush  in  1  discard buffered micro-ops (branch/interrupt redirect)
feed_req  out  1  ready to accept a new bundle from decode
feed_ack  in  1  decode hands over a bundle this cycle
uop_0  in  UOP_W  last micro-op of the bundle (always present)
uop_1  in  UOP_W  middle micro-op
uop_2  in  UOP_W  first micro-op, only when uop_count=2
uop_count  in  CNT_W  0: one micro-op; 1: two; 2: three; 3: illegal
uop_out  out  UOP_W  micro-op presented to execute
uop_valid  out  1  uop_out is valid
exec_ready  in  1  execute accepts uop_out this cycle
last_uop  out  1  uop_out is the final micro-op of its instruction
busy  out  1  a bundle is buffered
retired  out  PERF_W  count of instructions whose last micro-op has been accepted

Behaviour:
- Reset (a_rst=1, asynchronous) drives: buffer empty, slot index 0, retired=0. All outputs read 0 except feed_req, which reads 1 one cycle after reset is released.
- Buffer: three UOP_W registers plus a 2-bit remaining-count rem. rem=0 means the buffer is empty.
- accept = uop_valid & exec_ready (uop_valid already includes ~hold).
- feed_req = ~hold & ~flush & (rem==0 | (rem==1 & accept)). The lookahead allows back-to-back instructions with no bubble.
- capture = feed_req & feed_ack. On capture, load slots in issue order:
  - count 2: uop_2, uop_1, uop_0
  - count 1: uop_1, uop_0
  - count 0: uop_0
  - rem <= uop_count+1
- feed_ack while feed_req=0 is ignored (protocol violation; the bench asserts on it).
- Latency: capture in cycle N puts the first micro-op on uop_out in cycle N+1. The buffer is registered, with no bypass.
- uop_out = slot at the current issue index. uop_valid = (rem!=0) & ~hold. last_uop = (rem==1) & uop_valid.
- On accept: rem decrements and the index advances. If rem==1 and capture happens in the same cycle, the new bundle is loaded instead, and rem becomes the new count+1.
- retired increments by 1 on each accept with last_uop=1 and wraps at 2^PERF_W.
- hold=1: no state changes; uop_valid=0; feed_req=0. Values resume unchanged after hold drops.
- flush=1 with hold=0: rem <= 0, and any capture is suppressed (feed_req is already 0). A micro-op accepted in the flush cycle is not counted. Flush has priority over both accept and capture. Flush together with hold is held off until hold drops.
- uop_count=3: treated as count 2 (three micro-ops) and raises a simulation-only assertion.
- Reset mid-bundle: the buffer is discarded immediately and the retired count is lost.

Decomposition:
- Shared core package holds:
  - UOP_W
  - micro-op field offsets: alu fn [19:16], carry-unmask [15], ld [14], wr [13], write-flags [12], dest [11:8], wb-addr [7], sel-K [6], B sel [5:3], A sel [2:0]
  - uop_count encodings
- This block uses only UOP_W and the count encodings; execute uses the field offsets.
- No sub-module: the three-slot buffer and its index mux stay inline.

Test Plan:
1. Reset, then feed_ack with uop_count=0, uop_0=20'h7_0123, exec_ready=1 -> next cycle uop_out=20'h7_0123, uop_valid=1, last_uop=1; feed_req=1 in that same cycle; retired=1 afterward.
2. uop_count=2 with uop_2=A, uop_1=B, uop_0=C, exec_ready=1 -> A, B, C on three consecutive cycles; last_uop only with C; feed_req asserted in C's cycle; a second bundle D (count 0) follows with no bubble.
3. Count 1 bundle with exec_ready low for 3 cycles -> uop_out stays on the first micro-op with uop_valid=1; no index advance; feed_req=0.
4. hold=1 during the second micro-op of a count-2 bundle for 2 cycles -> uop_valid=0 and feed_req=0 during hold; same micro-op reappears afterward; retired is unchanged until the last micro-op is accepted.
5. flush in the cycle the second micro-op of a count-2 bundle is accepted -> next cycle rem=0, uop_valid=0, feed_req=1; retired is not incremented.
6. feed_ack pulsed while feed_req=0 (buffer holds a count-2 bundle) -> bundle ignored; the original micro-ops issue unchanged.

Source files
------------

// File: rtl/uop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uop_sequencer_pkg
// Purpose  : Shared core definitions: micro-op width, field offsets, and
//            uop_count encodings.
// Revision : 1.0 - initial release
// ============================================================================
package uop_sequencer_pkg;

    localparam int UOP_W = 20;

    // Micro-op field offsets, consumed by execute
    localparam int c_alu_fn_hi    = 19;
    localparam int c_alu_fn_lo    = 16;
    localparam int c_carry_unmask = 15;
    localparam int c_ld           = 14;
    localparam int c_wr           = 13;
    localparam int c_wr_flags     = 12;
    localparam int c_dest_hi      = 11;
    localparam int c_dest_lo      = 8;
    localparam int c_wb_addr      = 7;
    localparam int c_sel_k        = 6;
    localparam int c_b_sel_hi     = 5;
    localparam int c_b_sel_lo     = 3;
    localparam int c_a_sel_hi     = 2;
    localparam int c_a_sel_lo     = 0;

    // uop_count encodings
    localparam logic [1:0] c_cnt_one     = 2'd0;
    localparam logic [1:0] c_cnt_two     = 2'd1;
    localparam logic [1:0] c_cnt_three   = 2'd2;
    localparam logic [1:0] c_cnt_illegal = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uop_sequencer
// Purpose  : Captures a decoded micro-op bundle and issues it one micro-op
//            per cycle to execute, with hold, flush and a retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module uop_sequencer
    import uop_sequencer_pkg::*;
#(
    parameter int UOP_W  = uop_sequencer_pkg::UOP_W,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              hold,
    input  logic              flush,
    output logic              feed_req,
    input  logic              feed_ack,
    input  logic [UOP_W-1:0]  uop_0,
    input  logic [UOP_W-1:0]  uop_1,
    input  logic [UOP_W-1:0]  uop_2,
    input  logic [CNT_W-1:0]  uop_count,
    output logic [UOP_W-1:0]  uop_out,
    output logic              uop_valid,
    input  logic              exec_ready,
    output logic              last_uop,
    output logic              busy,
    output logic [PERF_W-1:0] retired
);

    logic [UOP_W-1:0]  r_slot0;
    logic [UOP_W-1:0]  r_slot1;
    logic [UOP_W-1:0]  r_slot2;
    logic [1:0]        r_idx;
    logic [1:0]        r_rem;
    logic              r_booted;
    logic [PERF_W-1:0] r_retired;

    logic              w_accept;
    logic              w_capture;
    logic [1:0]        w_cnt_eff;
    logic [1:0]        w_load_rem;
    logic [UOP_W-1:0]  w_uop;

    always_comb begin
        w_uop = r_slot0;
        case (r_idx)
            2'd1:    w_uop = r_slot1;
            2'd2:    w_uop = r_slot2;
            default: w_uop = r_slot0;
        endcase
    end

    assign uop_out   = w_uop;
    assign uop_valid = (r_rem != 2'd0) & ~hold;
    assign last_uop  = (r_rem == 2'd1) & uop_valid;
    assign busy      = (r_rem != 2'd0);
    assign retired   = r_retired;
    assign w_accept  = uop_valid & exec_ready;

    // Lookahead on the final micro-op lets the next bundle land without a bubble
    assign feed_req  = r_booted & ~hold & ~flush &
                       ((r_rem == 2'd0) | ((r_rem == 2'd1) & w_accept));
    assign w_capture = feed_req & feed_ack;

    assign w_cnt_eff  = (uop_count[1:0] == c_cnt_illegal) ? c_cnt_three : uop_count[1:0];
    assign w_load_rem = w_cnt_eff + 2'd1;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_slot0   <= '0;
            r_slot1   <= '0;
            r_slot2   <= '0;
            r_idx     <= 2'd0;
            r_rem     <= 2'd0;
            r_booted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_booted <= 1'b1;
            if (!hold) begin
                if (flush) begin
                    r_rem <= 2'd0;
                    r_idx <= 2'd0;
                end else if (w_capture) begin
                    r_rem <= w_load_rem;
                    r_idx <= 2'd0;
                    // Slots are filled in issue order, oldest in slot 0
                    case (w_cnt_eff)
                        c_cnt_three: begin
                            r_slot0 <= uop_2;
                            r_slot1 <= uop_1;
                            r_slot2 <= uop_0;
                        end
                        c_cnt_two: begin
                            r_slot0 <= uop_1;
                            r_slot1 <= uop_0;
                        end
                        default: begin
                            r_slot0 <= uop_0;
                        end
                    endcase
                end else if (w_accept) begin
                    r_rem <= r_rem - 2'd1;
                    r_idx <= r_idx + 2'd1;
                end

                if (!flush && w_accept && last_uop) begin
                    r_retired <= r_retired + 1'b1;
                end
            end
        end
    end

    // Simulation-only check on the illegal bundle size
    always @(posedge clk) begin
        if (!a_rst && w_capture) begin
            assert (uop_count[1:0] != c_cnt_illegal)
                else $error("uop_sequencer: uop_count=3 captured, issued as three micro-ops");
        end
    end

endmodule
`default_nettype wire
